vec_reg_file: RTL and testbench
===============================

// Module: vec_reg_file
// PURPOSE
//  Clocked, parametrised vector register file for the vector datapath: one lane-masked write port and two registered read ports (A, B).
//  A per-register busy scoreboard lets the sequencer reserve a destination register before issue.
//  Reads of a busy register stall until the pending write lands; a same-cycle write is bypassed to the reader.
//  Sits between the load/ALU result bus and the ALU operand inputs.
// PARAMETERS
//  BITS      8   lane width in bits
//  N         64  lanes per vector
//  NUM_REGS  16  register count; power of 2, >=2
//  SELW      $clog2(NUM_REGS)  select width (derived, do not override)
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          async active-low reset
//  wr_en      in   1          write strobe
//  wr_sel     in   SELW       destination register
//  wr_mask    in   N          per-lane write enable; bit i gates lane i
//  wr_data    in   [BITS][N]  write data, unpacked over lanes
//  rd_en_a    in   1          port A read request
//  rd_sel_a   in   SELW       port A source register
//  rd_data_a  out  [BITS][N]  port A data, registered
//  rd_valid_a out  1          port A data valid, registered
//  rd_stall_a out  1          comb: A request blocked this cycle
//  rd_en_b/rd_sel_b/rd_data_b/rd_valid_b/rd_stall_b  same as port A
//  rsv_en     in   1          reserve strobe (mark register busy)
//  rsv_sel    in   SELW       register to reserve
//  rsv_reject out  1          comb: reservation refused this cycle
//  busy       out  NUM_REGS   scoreboard, registered
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers, lanes, rd_data_*, rd_valid_*, and busy clear to 0. Clear takes effect immediately,
//   including mid-read; the first edge after release acts as a normal cycle.
//  Write: at edge with wr_en=1, lane i of reg[wr_sel] <= wr_data[i] iff wr_mask[i]. Lanes not selected by the mask hold.
//   wr_mask=0 still counts as a write for scoreboard purposes. busy[wr_sel] clears.
//  Read, per port X, at each edge:
//   - rd_en_X=0: rd_valid_X <= 0; rd_data_X holds.
//   - rd_en_X=1 and (!busy[sel], or wr_en with wr_sel==sel): rd_data_X <= reg[sel] merged with masked wr_data lanes
//     (write-first bypass); rd_valid_X <= 1. Latency is 1 cycle.
//   - rd_en_X=1, busy[sel]=1, no matching write: rd_stall_X=1; rd_valid_X <= 0; rd_data_X holds. The requester holds the request.
//   - rd_stall_X = rd_en_X & busy[sel] & !(wr_en & wr_sel==sel). It is 0 when rd_en_X=0.
//   - Ports are independent. A and B may read the same register in the same cycle.
//  Reserve: rsv_reject = rsv_en & busy[rsv_sel] & !(wr_en & wr_sel==rsv_sel).
//   If rsv_en=1 and not rejected, busy[rsv_sel] <= 1. If rejected, no state change.
//  Same-cycle write + reserve to the same register: the data is written and busy ends at 1 (reserve wins).
//  Reserve and read of the same idle register in the same cycle: the read is not stalled (it uses pre-edge busy) and returns old data.
//  wr_en to a register that is not busy is legal (busy stays 0).
//  All selects are fully decoded; there are no out-of-range values since NUM_REGS=2**SELW.
// TESTING
//  1. Reset, then read A reg3 and B reg15 -> next cycle rd_valid_a/b=1, all lanes 0, busy=0.
//  2. Write reg5 lanes=8'hA5, mask all 1; next cycle wr reg5 data 8'h3C with mask 64'h1 -> read reg5: lane0=3C, lanes1..63=A5.
//  3. Reserve reg7 -> busy[7]=1; read A reg7 -> rd_stall_a=1, rd_valid_a=0 for 3 cycles;
//     write reg7=8'h11 in the same cycle as the read -> rd_valid_a=1, data=11 next edge, busy[7]=0.
//  4. Reserve reg2 twice without a write -> second reserve gives rsv_reject=1, busy unchanged;
//     reserve reg2 with a same-cycle write to reg2 -> accepted, busy[2]=1.
//  5. Assert rst_n=0 mid-stall (reg9 busy, rd_en_b=1) -> busy, rd_valid_b, rd_data_b go 0 immediately; after release, read B reg9 returns 0, no stall.
//  6. Random write/reserve/read traffic with NUM_REGS=4, N=8, BITS=16 checked against a scoreboard model -> zero mismatches over 10k cycles.

Source files
------------

// File: rtl/vec_reg_file.sv
// Lane-masked vector register file: one write port, two registered read ports (1-cycle latency), busy scoreboard.
// Reads of a busy register stall (comb rd_stall_*) until a write to that register is seen; reservations of busy registers are rejected.
module vec_reg_file #(
  parameter int BITS     = 8,
  parameter int N        = 64,
  parameter int NUM_REGS = 16,
  localparam int SELW    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [SELW-1:0]     wr_sel,
  input  logic [N-1:0]        wr_mask,
  input  logic [BITS-1:0]     wr_data [N],
  input  logic                rd_en_a,
  input  logic [SELW-1:0]     rd_sel_a,
  output logic [BITS-1:0]     rd_data_a [N],
  output logic                rd_valid_a,
  output logic                rd_stall_a,
  input  logic                rd_en_b,
  input  logic [SELW-1:0]     rd_sel_b,
  output logic [BITS-1:0]     rd_data_b [N],
  output logic                rd_valid_b,
  output logic                rd_stall_b,
  input  logic                rsv_en,
  input  logic [SELW-1:0]     rsv_sel,
  output logic                rsv_reject,
  output logic [NUM_REGS-1:0] busy
);

  logic [BITS-1:0]     regs  [NUM_REGS][N];
  logic [BITS-1:0]     byp_a [N];
  logic [BITS-1:0]     byp_b [N];
  logic                hit_a, hit_b, hit_rsv;
  logic [NUM_REGS-1:0] busy_nxt;

  // A write landing on the same edge releases a busy register for readers and reservers alike.
  assign hit_a   = wr_en && (wr_sel == rd_sel_a);
  assign hit_b   = wr_en && (wr_sel == rd_sel_b);
  assign hit_rsv = wr_en && (wr_sel == rsv_sel);

  assign rd_stall_a = rd_en_a && busy[rd_sel_a] && !hit_a;
  assign rd_stall_b = rd_en_b && busy[rd_sel_b] && !hit_b;
  assign rsv_reject = rsv_en && busy[rsv_sel] && !hit_rsv;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      byp_a[i] = (hit_a && wr_mask[i]) ? wr_data[i] : regs[rd_sel_a][i];
      byp_b[i] = (hit_b && wr_mask[i]) ? wr_data[i] : regs[rd_sel_b][i];
    end
  end

  // Reserve is applied after the write clear so a same-register pair ends busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)
      busy_nxt[wr_sel] = 1'b0;
    if (rsv_en && !rsv_reject)
      busy_nxt[rsv_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        for (int i = 0; i < N; i++)
          regs[r][i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < N; i++)
        if (wr_mask[i])
          regs[wr_sel][i] <= wr_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_a <= 1'b0;
      for (int i = 0; i < N; i++)
        rd_data_a[i] <= '0;
    end else if (rd_en_a && !rd_stall_a) begin
      rd_valid_a <= 1'b1;
      rd_data_a  <= byp_a;
    end else begin
      rd_valid_a <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_b <= 1'b0;
      for (int i = 0; i < N; i++)
        rd_data_b[i] <= '0;
    end else if (rd_en_b && !rd_stall_b) begin
      rd_valid_b <= 1'b1;
      rd_data_b  <= byp_b;
    end else begin
      rd_valid_b <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_reg_file.sv
// Directed checks on the default-size register file, then randomized traffic on a small instance
// with a queue of expected responses consumed by an independent monitor.
module tb_vec_reg_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Default instance: BITS=8, N=64, NUM_REGS=16
  logic        wr_en, rd_en_a, rd_en_b, rsv_en;
  logic [3:0]  wr_sel, rd_sel_a, rd_sel_b, rsv_sel;
  logic [63:0] wr_mask;
  logic [7:0]  wr_data [64];
  logic [7:0]  rd_data_a [64];
  logic [7:0]  rd_data_b [64];
  logic        rd_valid_a, rd_valid_b, rd_stall_a, rd_stall_b, rsv_reject;
  logic [15:0] busy;

  vec_reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a),
    .rd_valid_a(rd_valid_a), .rd_stall_a(rd_stall_a),
    .rd_en_b(rd_en_b), .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b),
    .rd_valid_b(rd_valid_b), .rd_stall_b(rd_stall_b),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_reject(rsv_reject), .busy(busy)
  );

  // Small instance: BITS=16, N=8, NUM_REGS=4
  logic        s_wr_en, s_rd_en_a, s_rd_en_b, s_rsv_en;
  logic [1:0]  s_wr_sel, s_rd_sel_a, s_rd_sel_b, s_rsv_sel;
  logic [7:0]  s_wr_mask;
  logic [15:0] s_wr_data [8];
  logic [15:0] s_rd_data_a [8];
  logic [15:0] s_rd_data_b [8];
  logic        s_rd_valid_a, s_rd_valid_b, s_rd_stall_a, s_rd_stall_b, s_rsv_reject;
  logic [3:0]  s_busy;

  vec_reg_file #(.BITS(16), .N(8), .NUM_REGS(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_mask(s_wr_mask), .wr_data(s_wr_data),
    .rd_en_a(s_rd_en_a), .rd_sel_a(s_rd_sel_a), .rd_data_a(s_rd_data_a),
    .rd_valid_a(s_rd_valid_a), .rd_stall_a(s_rd_stall_a),
    .rd_en_b(s_rd_en_b), .rd_sel_b(s_rd_sel_b), .rd_data_b(s_rd_data_b),
    .rd_valid_b(s_rd_valid_b), .rd_stall_b(s_rd_stall_b),
    .rsv_en(s_rsv_en), .rsv_sel(s_rsv_sel), .rsv_reject(s_rsv_reject), .busy(s_busy)
  );

  typedef struct {
    bit               va;
    bit               vb;
    logic [7:0][15:0] da;
    logic [7:0][15:0] db;
    logic [3:0]       bsy;
  } ent_t;

  ent_t sq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Lane 0, lane 1 and all remaining lanes are compared against three expected bytes.
  task automatic chk_data(input string nm, input bit pb, input logic [7:0] l0, input logic [7:0] l1,
                          input logic [7:0] rest);
    logic [7:0] e, a;
    int bad_lane;
    bad_lane = -1;
    e = 8'h00;
    a = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      logic [7:0] ei, ai;
      ei = (i == 0) ? l0 : (i == 1) ? l1 : rest;
      ai = pb ? rd_data_b[i] : rd_data_a[i];
      if (ai !== ei) begin
        bad_lane = i;
        e = ei;
        a = ai;
      end
    end
    total++;
    if (bad_lane >= 0) begin
      bad++;
      $display("FAIL %s: lane %0d got %0h expected %0h", nm, bad_lane, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input logic [7:0] v);
    for (int i = 0; i < 64; i++) wr_data[i] = v;
  endtask

  // Reference model for the small instance
  logic [15:0]      mreg [4][8];
  bit   [3:0]       mbusy;
  logic [7:0][15:0] mda, mdb;

  initial begin
    wr_en = 0; rd_en_a = 0; rd_en_b = 0; rsv_en = 0;
    wr_sel = 0; rd_sel_a = 0; rd_sel_b = 0; rsv_sel = 0; wr_mask = '0;
    set_wd(8'h00);
    s_wr_en = 0; s_rd_en_a = 0; s_rd_en_b = 0; s_rsv_en = 0;
    s_wr_sel = 0; s_rd_sel_a = 0; s_rd_sel_b = 0; s_rsv_sel = 0; s_wr_mask = '0;
    for (int i = 0; i < 8; i++) s_wr_data[i] = '0;

    // Reset state, then reads of reg3 / reg15
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_valid_a", rd_valid_a, 0);
    chk("rst_valid_b", rd_valid_b, 0);
    rst_n = 1;
    rd_en_a = 1; rd_sel_a = 3; rd_en_b = 1; rd_sel_b = 15;
    step();
    chk("t1_valid_a", rd_valid_a, 1);
    chk("t1_valid_b", rd_valid_b, 1);
    chk_data("t1_data_a", 0, 8'h00, 8'h00, 8'h00);
    chk_data("t1_data_b", 1, 8'h00, 8'h00, 8'h00);
    chk("t1_busy", busy, 0);
    rd_en_a = 0; rd_en_b = 0;

    // Masked writes and write-first bypass
    wr_en = 1; wr_sel = 5; wr_mask = '1; set_wd(8'hA5);
    step();
    wr_mask = 64'h1; set_wd(8'h3C);
    step();
    wr_en = 0; rd_en_a = 1; rd_sel_a = 5;
    step();
    chk("t2_valid", rd_valid_a, 1);
    chk_data("t2_merge", 0, 8'h3C, 8'hA5, 8'hA5);
    wr_en = 1; wr_mask = 64'h2; set_wd(8'h77);
    step();
    chk_data("t2_bypass", 0, 8'h3C, 8'h77, 8'hA5);
    wr_en = 0; rd_en_a = 0;
    step();
    chk("t2_idle_valid", rd_valid_a, 0);
    chk_data("t2_hold", 0, 8'h3C, 8'h77, 8'hA5);

    // Reserve, stall, release by write
    rsv_en = 1; rsv_sel = 7;
    #1 chk("t3_rsv_ok", rsv_reject, 0);
    step();
    rsv_en = 0;
    chk("t3_busy", busy, 16'h0080);
    rd_en_a = 1; rd_sel_a = 7;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t3_stall", rd_stall_a, 1);
      step();
      chk("t3_nvalid", rd_valid_a, 0);
    end
    wr_en = 1; wr_sel = 7; wr_mask = '1; set_wd(8'h11);
    #1 chk("t3_unstall", rd_stall_a, 0);
    step();
    wr_en = 0; rd_en_a = 0;
    chk("t3_valid", rd_valid_a, 1);
    chk_data("t3_data", 0, 8'h11, 8'h11, 8'h11);
    chk("t3_busy_clr", busy, 0);

    // Double reserve rejected; reserve with same-cycle write accepted
    rsv_en = 1; rsv_sel = 2;
    step();
    #1 chk("t4_reject", rsv_reject, 1);
    step();
    chk("t4_busy_same", busy, 16'h0004);
    wr_en = 1; wr_sel = 2; wr_mask = '1; set_wd(8'h5A);
    #1 chk("t4_accept", rsv_reject, 0);
    step();
    wr_en = 0; rsv_en = 0;
    chk("t4_busy_win", busy, 16'h0004);

    // Async reset during a stall
    rsv_en = 1; rsv_sel = 9;
    step();
    rsv_en = 0;
    chk("t5_busy", busy, 16'h0204);
    rd_en_b = 1; rd_sel_b = 5;
    step();
    chk("t5_pre_valid", rd_valid_b, 1);
    rd_sel_b = 9;
    #1 chk("t5_stall", rd_stall_b, 1);
    rst_n = 0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", rd_valid_b, 0);
    chk_data("t5_rst_data", 1, 8'h00, 8'h00, 8'h00);
    rst_n = 1;
    #1 chk("t5_no_stall", rd_stall_b, 0);
    rd_en_a = 1; rd_sel_a = 5;
    step();
    chk("t5_valid", rd_valid_b, 1);
    chk_data("t5_data_b", 1, 8'h00, 8'h00, 8'h00);
    chk_data("t5_reg5_cleared", 0, 8'h00, 8'h00, 8'h00);
    rd_en_a = 0; rd_en_b = 0;

    // Randomized traffic on the small instance
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) mreg[r][i] = '0;
    mbusy = '0; mda = '0; mdb = '0;
    for (int c = 0; c < 10000; c++) begin
      ent_t e;
      bit hit_a, hit_b, st_a, st_b, rej;
      @(negedge clk);
      s_wr_en   = ($urandom_range(0, 9) < 4);
      s_rsv_en  = ($urandom_range(0, 9) < 3);
      s_rd_en_a = ($urandom_range(0, 9) < 7);
      s_rd_en_b = ($urandom_range(0, 9) < 7);
      s_wr_sel = 2'($urandom); s_rd_sel_a = 2'($urandom);
      s_rd_sel_b = 2'($urandom); s_rsv_sel = 2'($urandom);
      s_wr_mask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      for (int i = 0; i < 8; i++) s_wr_data[i] = 16'($urandom);

      hit_a = s_wr_en && s_wr_sel == s_rd_sel_a;
      hit_b = s_wr_en && s_wr_sel == s_rd_sel_b;
      st_a = s_rd_en_a && mbusy[s_rd_sel_a] && !hit_a;
      st_b = s_rd_en_b && mbusy[s_rd_sel_b] && !hit_b;
      rej  = s_rsv_en && mbusy[s_rsv_sel] && !(s_wr_en && s_wr_sel == s_rsv_sel);
      if (s_rd_en_a && !st_a)
        for (int i = 0; i < 8; i++)
          mda[i] = (hit_a && s_wr_mask[i]) ? s_wr_data[i] : mreg[s_rd_sel_a][i];
      if (s_rd_en_b && !st_b)
        for (int i = 0; i < 8; i++)
          mdb[i] = (hit_b && s_wr_mask[i]) ? s_wr_data[i] : mreg[s_rd_sel_b][i];
      if (s_wr_en) begin
        for (int i = 0; i < 8; i++)
          if (s_wr_mask[i]) mreg[s_wr_sel][i] = s_wr_data[i];
        mbusy[s_wr_sel] = 0;
      end
      if (s_rsv_en && !rej) mbusy[s_rsv_sel] = 1;

      e.va = s_rd_en_a && !st_a;
      e.vb = s_rd_en_b && !st_b;
      e.da = mda;
      e.db = mdb;
      e.bsy = mbusy;
      sq.push_back(e);

      #1;
      chk("r_stall_a", s_rd_stall_a, st_a);
      chk("r_stall_b", s_rd_stall_b, st_b);
      chk("r_reject", s_rsv_reject, rej);
    end
    @(posedge clk);
    #2;
    chk("r_queue_drained", sq.size(), 0);
    s_wr_en = 0; s_rsv_en = 0; s_rd_en_a = 0; s_rd_en_b = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: one expected entry is consumed per clock once random traffic has started.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        ent_t e;
        logic [7:0][15:0] ga, gb;
        e = sq.pop_front();
        for (int i = 0; i < 8; i++) begin
          ga[i] = s_rd_data_a[i];
          gb[i] = s_rd_data_b[i];
        end
        chk("m_valid_a", s_rd_valid_a, e.va);
        chk("m_valid_b", s_rd_valid_b, e.vb);
        chk("m_data_a", ga[3:0], e.da[3:0]);
        chk("m_data_a_hi", ga[7:4], e.da[7:4]);
        chk("m_data_b", gb[3:0], e.db[3:0]);
        chk("m_data_b_hi", gb[7:4], e.db[7:4]);
        chk("m_busy", s_busy, e.bsy);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
